// File: rtl/sipo_frame_ctrl_if.sv
// Bus bundle for sipo_frame_ctrl: serial input side plus parallel valid/ready output.
// The parity_err signal exists only when PARITY_CHECK_EN is defined.
// master: the controller (drives q/q_valid/busy/overrun); slave: source/consumer side.
interface sipo_frame_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             busy;
  logic             overrun;
`ifdef PARITY_CHECK_EN
  logic             parity_err;

  modport master (
    input  start, d, q_ready,
    output q, q_valid, busy, overrun, parity_err
  );
  modport slave (
    output start, d, q_ready,
    input  q, q_valid, busy, overrun, parity_err
  );
`else
  modport master (
    input  start, d, q_ready,
    output q, q_valid, busy, overrun
  );
  modport slave (
    output start, d, q_ready,
    input  q, q_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames WIDTH serial bits into a word, holds it for a valid/ready
// consumer, and pulses overrun when a completed word is dropped under backpressure.
// Optional feature macro: PARITY_CHECK_EN adds an even-parity bit after the data
// bits (PARITY state) and the parity_err flag that qualifies q.
//
//   state  | meaning
//   IDLE   | waiting for start; d ignored
//   SHIFT  | sampling one data bit per cycle
//   PARITY | sampling the parity bit (PARITY_CHECK_EN only)
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  sipo_frame_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             overrun_q, overrun_d;
  logic             complete;
`ifdef PARITY_CHECK_EN
  logic             par_err_q, par_err_d;
  logic             word_err;
`endif

  // Shift register value with this cycle's d folded in, in the configured direction
  always_comb begin
    if (MSB_FIRST) sreg_shift = {sreg_q[WIDTH-2:0], bus.d};
    else           sreg_shift = {bus.d, sreg_q[WIDTH-1:1]};
  end

  // Frame sequencing: next state, bit counter, completion strobe and completed word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    complete = 1'b0;
    word     = sreg_q;
`ifdef PARITY_CHECK_EN
    word_err = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sreg_d = sreg_shift;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
          state_d = PARITY;
`else
          complete = 1'b1;
          word     = sreg_shift;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        complete = 1'b1;
        word     = sreg_q;
        word_err = ^{sreg_q, bus.d};
      end
`endif
      default: state_d = IDLE;
    endcase
    // A start seen on the completing cycle chains straight into the next frame
    if (complete) begin
      if (bus.start) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Holding register and handshake: load, replace on same-edge consume, or drop
  always_comb begin
    q_d       = q_q;
    q_valid_d = q_valid_q;
    overrun_d = 1'b0;
`ifdef PARITY_CHECK_EN
    par_err_d = par_err_q;
`endif
    if (complete) begin
      if (!q_valid_q || bus.q_ready) begin
        q_d       = word;
        q_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
        par_err_d = word_err;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (q_valid_q && bus.q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  // State and datapath registers, cleared asynchronously so a partial frame is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = par_err_q;
`endif

endmodule
